primo_nth: RTL and testbench
============================

Name: primo_nth

Overview:
- Initiator side of the prime generator's go/ready/error handshake.
- Accepts an index n, drives an external generator instance, and returns the n-th prime (index 1 = 2, index 2 = 3, ...).
- Owns the generator's go and synchronous reset lines, counts completed handshakes, and captures the result.
- Sits between the host/test harness and one generator instance; the generator is instantiated alongside it, not inside it.

Parameters:
- WIDTH_LOG, 4, log2 of prime width; WIDTH = 1 << WIDTH_LOG, must match the attached generator.
- CNT_WIDTH, 8, width of index n and the internal handshake counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while ready=1.
- n  input  CNT_WIDTH  requested prime index; captured on start acceptance.
- ready  output  1  idle and result valid (registered).
- error  output  1  last request failed (registered).
- prime  output  WIDTH  result (registered).
- gen_go  output  1  go pulse to generator.
- gen_rst  output  1  active-high synchronous reset to generator.
- gen_ready  input  1  generator ready.
- gen_error  input  1  generator error/overflow.
- gen_res  input  WIDTH  generator current value.

Behaviour:
- Async reset (rst_n=0), effective immediately:
  - state=IDLE, ready=1, error=0, prime=0, gen_go=0, gen_rst=1, counter=0.
  - Holding gen_rst high keeps the generator in reset while this block is in reset.
- States: IDLE, GRST, ISSUE, GAP, WAIT, ERR. Outputs are registered from next-state logic.
- IDLE/ERR:
  - gen_rst=0.
  - start=1 → latch n, clear counter, ready<=0, error<=0, go to GRST.
  - start while ready=0 is ignored; n is not re-sampled.
- GRST (one cycle):
  - gen_rst=1 for exactly one clock; the generator restarts at value 1.
  - n==0 → go to IDLE; prime<=1, ready<=1. n==0 is defined as "generator reset value".
  - Otherwise go to ISSUE.
- ISSUE:
  - Waits for gen_ready=1, then asserts gen_go=1 for exactly one cycle and goes to GAP.
- GAP (one cycle):
  - Blanks out gen_ready, which the generator drops one cycle after go. gen_go=0.
- WAIT, staying until gen_ready=1, then:
  - gen_error=1 → ERR; error<=1, ready<=1, prime unchanged.
  - Otherwise counter+1; if counter+1 == n → IDLE, prime<=gen_res, ready<=1.
  - Otherwise → ISSUE.
- Latency for n≥1: 2 cycles, plus n × (generator latency + 2), plus 1 cycle output register.
- Counter wrap: impossible, since the counter stops at n ≤ 2^CNT_WIDTH−1.
- gen_go is never asserted while gen_rst=1 or while gen_ready=0.
- Mid-operation rst_n: aborts at once with the reset values above; no partial result is ever presented with ready=1.

Optional Feature:
- Macro: PRIMO_RESUME_EN.
- Defined:
  - The block keeps last_n (the counter value after the last successful request).
  - On start with n ≥ last_n and no error since the last reset, GRST is skipped. Counting continues from last_n and only n−last_n go pulses are issued.
  - n == last_n → result returns in 1 cycle (prime unchanged, ready<=1).
  - n < last_n, or a previous ERR → full restart through GRST.
  - last_n resets to 0.
- Undefined: every request passes through GRST.

Test Plan:
- Reset release, then start with n=1 → exactly one gen_rst pulse, one gen_go pulse; ready=1, prime=2, error=0.
- n=5 → five gen_go pulses, each issued only with gen_ready=1; prime=11. Then n=3 → gen_rst pulse seen, prime=5.
- n=0 → no gen_go; ready high 2 cycles after acceptance; prime=1.
- Stub generator asserts gen_error on the 3rd handshake of n=6 → error=1, ready=1, prime unchanged. Next start with n=2 → error=0, prime=3.
- start pulsed during WAIT with a different n → ignored; original request completes with the correct prime. Separately, rst_n=0 mid-WAIT → ready=1, gen_rst=1, gen_go=0 immediately.
- PRIMO_RESUME_EN:
  - n=3 → 5, then n=6 → 13 with no gen_rst pulse and exactly three gen_go pulses.
  - Then n=2 → gen_rst pulse, prime=3.

Source files
------------

// File: rtl/primo_nth.sv
// primo_nth: initiator for the prime generator go/ready/error handshake; returns the n-th prime.
// Optional feature macro PRIMO_RESUME_EN: resume counting from the last completed index.
module primo_nth #(
  parameter int WIDTH_LOG = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        n,
  output logic                        ready,
  output logic                        error,
  output logic [(1<<WIDTH_LOG)-1:0]   prime,
  output logic                        gen_go,
  output logic                        gen_rst,
  input  logic                        gen_ready,
  input  logic                        gen_error,
  input  logic [(1<<WIDTH_LOG)-1:0]   gen_res
);

  localparam int WIDTH = 1 << WIDTH_LOG;

  // Handshake: gen_go is a one-cycle pulse issued only while gen_ready=1 and
  // gen_rst=0; the generator drops gen_ready the cycle after it sees gen_go and
  // raises it again (with gen_res/gen_error valid) when the step completes.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRST  = 3'd1,
    ISSUE = 3'd2,
    GAP   = 3'd3,
    WAIT  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] n_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;

`ifdef PRIMO_RESUME_EN
  logic [CNT_WIDTH-1:0] last_n;
  logic                 resume_ok;
`endif

  assign cnt_inc = cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      error   <= 1'b0;
      prime   <= '0;
      gen_go  <= 1'b0;
      gen_rst <= 1'b1;
      n_q     <= '0;
      cnt     <= '0;
`ifdef PRIMO_RESUME_EN
      last_n    <= '0;
      resume_ok <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE, ERR: begin
          gen_rst <= 1'b0;
          gen_go  <= 1'b0;
          if (start) begin
            n_q   <= n;
            error <= 1'b0;
`ifdef PRIMO_RESUME_EN
            // The generator still holds the last_n-th prime, so counting can continue.
            if (resume_ok && (n >= last_n)) begin
              cnt <= last_n;
              if (n == last_n) begin
                state <= IDLE;
                ready <= 1'b1;
              end else begin
                state <= ISSUE;
                ready <= 1'b0;
              end
            end else begin
              cnt     <= '0;
              ready   <= 1'b0;
              gen_rst <= 1'b1;
              state   <= GRST;
            end
`else
            cnt     <= '0;
            ready   <= 1'b0;
            gen_rst <= 1'b1;
            state   <= GRST;
`endif
          end
        end

        GRST: begin
          gen_rst <= 1'b0;
`ifdef PRIMO_RESUME_EN
          resume_ok <= 1'b1;
`endif
          if (n_q == '0) begin
            prime <= WIDTH'(1);
            ready <= 1'b1;
            state <= IDLE;
`ifdef PRIMO_RESUME_EN
            last_n <= '0;
`endif
          end else begin
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (gen_ready) begin
            gen_go <= 1'b1;
            state  <= GAP;
          end
        end

        // gen_ready is stale during the go cycle; skip it before watching for completion.
        GAP: begin
          gen_go <= 1'b0;
          state  <= WAIT;
        end

        WAIT: begin
          if (gen_ready) begin
            if (gen_error) begin
              error <= 1'b1;
              ready <= 1'b1;
              state <= ERR;
`ifdef PRIMO_RESUME_EN
              resume_ok <= 1'b0;
`endif
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == n_q) begin
                prime <= gen_res;
                ready <= 1'b1;
                state <= IDLE;
`ifdef PRIMO_RESUME_EN
                last_n <= cnt_inc;
`endif
              end else begin
                state <= ISSUE;
              end
            end
          end
        end

        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          gen_go  <= 1'b0;
          gen_rst <= 1'b0;
        end
      endcase
    end
  end

  a_go_safe: assert property (@(posedge clk) disable iff (!rst_n)
    gen_go |-> (!gen_rst && gen_ready));

  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    ready |-> (state == IDLE || state == ERR));

endmodule

// File: tb/tb_primo_nth.sv
// tb_primo_nth: drives primo_nth against a behavioural prime generator stub with a result scoreboard.
module tb_primo_nth;

  localparam int WIDTH_LOG = 4;
  localparam int CNT_WIDTH = 8;
  localparam int WIDTH     = 1 << WIDTH_LOG;

`ifdef PRIMO_RESUME_EN
  localparam bit RESUME = 1'b1;
`else
  localparam bit RESUME = 1'b0;
`endif

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CNT_WIDTH-1:0] n     = '0;
  logic                 ready;
  logic                 error;
  logic [WIDTH-1:0]     prime;
  logic                 gen_go;
  logic                 gen_rst;
  logic                 gen_ready;
  logic                 gen_error;
  logic [WIDTH-1:0]     gen_res;

  always #5 clk = ~clk;

  primo_nth #(.WIDTH_LOG(WIDTH_LOG), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n         (n),
    .ready     (ready),
    .error     (error),
    .prime     (prime),
    .gen_go    (gen_go),
    .gen_rst   (gen_rst),
    .gen_ready (gen_ready),
    .gen_error (gen_error),
    .gen_res   (gen_res)
  );

  // ---------------- generator stub ----------------
  logic [WIDTH-1:0] g_val    = 16'd1;
  logic             g_ready  = 1'b1;
  logic             g_err    = 1'b0;
  int               g_timer  = 0;
  int               g_hs     = 0;
  int               g_err_at = 0;
  int               g_lat    = 0;

  assign gen_ready = g_ready;
  assign gen_error = g_err;
  assign gen_res   = g_val;

  function automatic logic [WIDTH-1:0] next_prime(input logic [WIDTH-1:0] v);
    int c;
    bit is_p;
    c = int'(v) + 1;
    for (int k = 0; k < 1000; k++) begin
      is_p = (c >= 2);
      for (int d = 2; d * d <= c; d++) if (c % d == 0) is_p = 1'b0;
      if (is_p) return WIDTH'(c);
      c++;
    end
    return WIDTH'(c);
  endfunction

  always @(posedge clk) begin
    if (gen_rst) begin
      g_val   <= 16'd1;
      g_ready <= 1'b1;
      g_err   <= 1'b0;
      g_hs    <= 0;
      g_timer <= 0;
    end else if (gen_go && g_ready) begin
      g_ready <= 1'b0;
      g_err   <= 1'b0;
      g_hs    <= g_hs + 1;
      g_timer <= (g_lat > 0) ? g_lat : int'($urandom_range(1, 4));
    end else if (!g_ready) begin
      if (g_timer <= 1) begin
        g_ready <= 1'b1;
        g_val   <= next_prime(g_val);
        g_err   <= (g_hs == g_err_at);
      end else begin
        g_timer <= g_timer - 1;
      end
    end
  end

  // ---------------- handshake monitor ----------------
  int go_cyc  = 0;
  int rst_cyc = 0;
  int go_viol = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (gen_go) go_cyc++;
      if (gen_rst) rst_cyc++;
      if (gen_go && (!gen_ready || gen_rst)) go_viol++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];
  int vec = 0;
  int bad = 0;

  localparam logic [WIDTH-1:0] PRIMES [0:12] =
    '{16'd1, 16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19, 16'd23, 16'd29, 16'd31, 16'd37};

  task automatic issue(input logic [CNT_WIDTH-1:0] idx, input logic exp_err, input logic [WIDTH-1:0] exp_p);
    @(negedge clk);
    start   = 1'b1;
    n       = idx;
    go_cyc  = 0;
    rst_cyc = 0;
    exp_q.push_back({exp_err, exp_p});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    while (!ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ok = ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({ready, error, prime, gen_go, gen_rst} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: ready/error/prime/go/rst=%b/%b/%0d/%b/%b want 1/0/0/0/1",
               ready, error, prime, gen_go, gen_rst);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if ({ready, gen_rst} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release: ready/gen_rst=%b/%b want 1/0", ready, gen_rst);
    end
  endtask

  task automatic test_first();
    bit ok;
    logic [WIDTH:0] e;
    issue(8'd1, 1'b0, PRIMES[1]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL n1_result: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (go_cyc !== 1 || rst_cyc !== (RESUME ? 0 : 1)) begin
      bad++;
      $display("FAIL n1_pulses: go/rst=%0d/%0d want 1/%0d", go_cyc, rst_cyc, RESUME ? 0 : 1);
    end
  endtask

  task automatic test_multi();
    bit ok;
    logic [WIDTH:0] e;
    issue(8'd5, 1'b0, PRIMES[5]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL n5_result: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (go_cyc !== (RESUME ? 4 : 5) || go_viol !== 0) begin
      bad++;
      $display("FAIL n5_go: go/viol=%0d/%0d want %0d/0", go_cyc, go_viol, RESUME ? 4 : 5);
    end
    issue(8'd3, 1'b0, PRIMES[3]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL n3_result: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (rst_cyc !== 1 || go_cyc !== 3) begin
      bad++;
      $display("FAIL n3_pulses: rst/go=%0d/%0d want 1/3", rst_cyc, go_cyc);
    end
  endtask

  task automatic test_zero();
    logic [WIDTH:0] e;
    issue(8'd0, 1'b0, PRIMES[0]);
    vec++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL n0_busy: ready=%b want 0", ready);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    vec++;
    if ({ready, error, prime} !== {1'b1, e}) begin
      bad++;
      $display("FAIL n0_result: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (go_cyc !== 0 || rst_cyc !== 1) begin
      bad++;
      $display("FAIL n0_pulses: go/rst=%0d/%0d want 0/1", go_cyc, rst_cyc);
    end
  endtask

  task automatic test_error();
    bit ok;
    logic [WIDTH:0] e;
    g_err_at = 3;
    issue(8'd6, 1'b1, PRIMES[0]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL err_result: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (go_cyc !== 3) begin
      bad++;
      $display("FAIL err_go: go=%0d want 3", go_cyc);
    end
    g_err_at = 0;
    issue(8'd2, 1'b0, PRIMES[2]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL after_err: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (rst_cyc !== 1) begin
      bad++;
      $display("FAIL after_err_rst: rst=%0d want 1", rst_cyc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    logic [WIDTH:0] e;
    issue(8'd4, 1'b0, PRIMES[4]);
    k = 0;
    while (!gen_go && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    start = 1'b1;
    n     = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL ignore_start: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (go_cyc !== (RESUME ? 2 : 4)) begin
      bad++;
      $display("FAIL ignore_start_go: go=%0d want %0d", go_cyc, RESUME ? 2 : 4);
    end
  endtask

  task automatic test_abort();
    int k;
    g_lat = 5;
    @(negedge clk);
    start = 1'b1;
    n     = 8'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!gen_go && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({ready, gen_rst, gen_go} !== 3'b110) begin
      bad++;
      $display("FAIL abort_now: ready/gen_rst/gen_go=%b/%b/%b want 1/1/0", ready, gen_rst, gen_go);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g_lat = 0;
    @(negedge clk);
    vec++;
    if ({ready, error, prime} !== {1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL abort_clean: ready/error/prime=%b/%b/%0d want 1/0/0", ready, error, prime);
    end
  endtask

  task automatic test_resume();
    bit ok;
    logic [WIDTH:0] e;
    issue(8'd3, 1'b0, PRIMES[3]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL res_n3: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    issue(8'd6, 1'b0, PRIMES[6]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e) begin
      bad++;
      $display("FAIL res_n6: ready/error/prime=%b/%b/%0d want 1/%b/%0d", ready, error, prime, e[WIDTH], e[WIDTH-1:0]);
    end
    vec++;
    if (rst_cyc !== (RESUME ? 0 : 1) || go_cyc !== (RESUME ? 3 : 6)) begin
      bad++;
      $display("FAIL res_n6_pulses: rst/go=%0d/%0d want %0d/%0d", rst_cyc, go_cyc, RESUME ? 0 : 1, RESUME ? 3 : 6);
    end
    issue(8'd6, 1'b0, PRIMES[6]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e || go_cyc !== (RESUME ? 0 : 6)) begin
      bad++;
      $display("FAIL res_same: ready/prime/go=%b/%0d/%0d want 1/%0d/%0d", ready, prime, go_cyc, e[WIDTH-1:0], RESUME ? 0 : 6);
    end
    issue(8'd2, 1'b0, PRIMES[2]);
    wait_ready(ok);
    e = exp_q.pop_front();
    vec++;
    if (!ok || {error, prime} !== e || rst_cyc !== 1) begin
      bad++;
      $display("FAIL res_n2: ready/prime/rst=%b/%0d/%0d want 1/%0d/1", ready, prime, rst_cyc, e[WIDTH-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_multi();
    test_zero();
    test_error();
    test_back_to_back();
    test_abort();
    test_resume();
    vec++;
    if (exp_q.size() != 0 || go_viol !== 0) begin
      bad++;
      $display("FAIL drain: queue=%0d viol=%0d want 0/0", exp_q.size(), go_viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
